// File: rtl/cache_sa_wb.sv
// cache_sa_wb: N-way set-associative, write-back, write-allocate data cache in front of a 64-bit backing memory.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss/writeback counters as output ports.
module cache_sa_wb #(
    parameter int ADDR_WIDTH      = 20,
    parameter int WAYS            = 2,
    parameter int SETS            = 8,
    parameter int WORDS_PER_BLOCK = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [63:0]           data_in,
    input  logic [7:0]            bytemask,
    input  logic                  write,
    input  logic                  start_access,
    output logic                  access_done,
    output logic [63:0]           data_out,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [63:0]           mem_data_out,
    output logic                  mem_write,
    output logic                  mem_start,
    input  logic                  mem_done,
    input  logic [63:0]           mem_data_in
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int WCNT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W  = ADDR_WIDTH - 3 - OFF_W - IDX_W;
    localparam int NLINES = SETS * WAYS;
    localparam int NWORDS = NLINES * WORDS_PER_BLOCK;
    localparam int LINE_W = $clog2(NLINES);
    localparam int DIDX_W = $clog2(NWORDS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [63:0]       data_mem [NWORDS];
    logic [TAG_W-1:0]  tag_mem  [NLINES];
    logic [NLINES-1:0] valid_reg;
    logic [NLINES-1:0] dirty_reg;
    logic [WAY_W-1:0]  rr_ptr   [SETS];

    logic [WCNT_W-1:0] word_cnt_reg;
    logic [LINE_W-1:0] vline_reg;
    logic              victim_rr_reg;
    logic [TAG_W-1:0]  wb_tag_reg;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WCNT_W-1:0] req_word;
    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim_way;
    logic [LINE_W-1:0] victim_line;
    logic [LINE_W-1:0] hit_line;
    logic              victim_dirty;
    logic [63:0]       hit_word;
    logic [63:0]       merged_word;
    logic              last_word;
    logic [WCNT_W-1:0] word_inc;
    logic              wr_en;
    logic [DIDX_W-1:0] wr_addr;
    logic [63:0]       wr_data;

    function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] s, input logic [WAY_W-1:0] w);
        return LINE_W'(s) * LINE_W'(WAYS) + LINE_W'(w);
    endfunction

    function automatic logic [DIDX_W-1:0] word_of(input logic [LINE_W-1:0] l, input logic [WCNT_W-1:0] w);
        return DIDX_W'(l) * DIDX_W'(WORDS_PER_BLOCK) + DIDX_W'(w);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] s,
                                                        input logic [WCNT_W-1:0] w);
        return (ADDR_WIDTH'(t) << (3 + OFF_W + IDX_W)) | (ADDR_WIDTH'(s) << (3 + OFF_W)) | (ADDR_WIDTH'(w) << 3);
    endfunction

    assign req_tag   = address[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx   = address[3+OFF_W +: IDX_W];
    assign req_word  = (OFF_W > 0) ? WCNT_W'(address >> 3) : '0;
    assign last_word = (word_cnt_reg == WCNT_W'(WORDS_PER_BLOCK - 1));
    assign word_inc  = word_cnt_reg + 1'b1;

    genvar gi;
    for (gi = 0; gi < WAYS; gi++) begin : g_way
        logic [LINE_W-1:0] ln;
        assign ln          = line_of(req_idx, WAY_W'(gi));
        assign hit_vec[gi] = valid_reg[ln] && (tag_mem[ln] == req_tag);
    end

    // Hit way and lowest-index invalid way; the victim falls back to the round-robin pointer.
    always_comb begin
        hit       = |hit_vec;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WAY_W'(i);
            if (!valid_reg[line_of(req_idx, WAY_W'(i))]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end
    end

    assign victim_way   = inv_found ? inv_way : rr_ptr[req_idx];
    assign victim_line  = line_of(req_idx, victim_way);
    assign victim_dirty = valid_reg[victim_line] && dirty_reg[victim_line];
    assign hit_line     = line_of(req_idx, hit_way);
    assign hit_word     = data_mem[word_of(hit_line, req_word)];

    for (gi = 0; gi < 8; gi++) begin : g_byte
        assign merged_word[gi*8 +: 8] = bytemask[gi] ? data_in[gi*8 +: 8] : hit_word[gi*8 +: 8];
    end

    // Single data-array write port shared by hit-write merges and fill beats.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = word_of(hit_line, req_word);
        wr_data = merged_word;
        if (state_reg == S_LOOKUP && hit && write) begin
            wr_en = 1'b1;
        end else if (state_reg == S_FILL && mem_done) begin
            wr_en   = 1'b1;
            wr_addr = word_of(vline_reg, word_cnt_reg);
            wr_data = mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_addr] <= wr_data;
        if (state_reg == S_FILL && mem_done && last_word) tag_mem[vline_reg] <= req_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start_access) state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (hit)               state_next = S_DONE;
                else if (victim_dirty) state_next = S_WB;
                else                   state_next = S_FILL;
            end
            S_WB:     if (mem_done && last_word) state_next = S_FILL;
            S_FILL:   if (mem_done && last_word) state_next = S_LOOKUP;
            S_DONE:   state_next = start_access ? S_LOOKUP : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        access_done = (state_reg == S_DONE);
    end

    // mem_start stays high from the first writeback beat through the last fill beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out      <= '0;
            mem_start     <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_data_out  <= '0;
            word_cnt_reg  <= '0;
            vline_reg     <= '0;
            victim_rr_reg <= 1'b0;
            wb_tag_reg    <= '0;
            valid_reg     <= '0;
            dirty_reg     <= '0;
            for (int i = 0; i < SETS; i++) rr_ptr[i] <= '0;
        end else begin
            case (state_reg)
                S_LOOKUP: begin
                    if (hit) begin
                        if (write) dirty_reg[hit_line] <= 1'b1;
                        else       data_out <= hit_word;
                    end else begin
                        vline_reg     <= victim_line;
                        victim_rr_reg <= !inv_found;
                        wb_tag_reg    <= tag_mem[victim_line];
                        word_cnt_reg  <= '0;
                        mem_start     <= 1'b1;
                        if (victim_dirty) begin
                            mem_write    <= 1'b1;
                            mem_address  <= make_addr(tag_mem[victim_line], req_idx, '0);
                            mem_data_out <= data_mem[word_of(victim_line, '0)];
                        end else begin
                            mem_write   <= 1'b0;
                            mem_address <= make_addr(req_tag, req_idx, '0);
                        end
                    end
                end
                S_WB: begin
                    if (mem_done) begin
                        if (last_word) begin
                            word_cnt_reg <= '0;
                            mem_write    <= 1'b0;
                            mem_address  <= make_addr(req_tag, req_idx, '0);
                        end else begin
                            word_cnt_reg <= word_inc;
                            mem_address  <= make_addr(wb_tag_reg, req_idx, word_inc);
                            mem_data_out <= data_mem[word_of(vline_reg, word_inc)];
                        end
                    end
                end
                S_FILL: begin
                    if (mem_done) begin
                        if (last_word) begin
                            mem_start            <= 1'b0;
                            word_cnt_reg         <= '0;
                            valid_reg[vline_reg] <= 1'b1;
                            dirty_reg[vline_reg] <= 1'b0;
                            if (victim_rr_reg) rr_ptr[req_idx] <= (WAYS > 1) ? rr_ptr[req_idx] + 1'b1 : '0;
                        end else begin
                            word_cnt_reg <= word_inc;
                            mem_address  <= make_addr(req_tag, req_idx, word_inc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // refill_reg marks the re-lookup after a fill so it is not counted as a hit.
    logic refill_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refill_reg <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state_reg == S_FILL)        refill_reg <= 1'b1;
            else if (state_reg != S_LOOKUP) refill_reg <= 1'b0;
            if (state_reg == S_LOOKUP && hit && !refill_reg && hit_count != '1) hit_count <= hit_count + 1'b1;
            if (state_reg == S_LOOKUP && !hit && miss_count != '1) miss_count <= miss_count + 1'b1;
            if (state_reg == S_WB && mem_done && last_word && wb_count != '1) wb_count <= wb_count + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    addr_aligned_a: assert property (@(posedge clk) disable iff (!reset) start_access |-> address[2:0] == 3'b000);
`endif

endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed-vector bench for cache_sa_wb (default parameters) with a fixed 4-cycle backing memory model.
`timescale 1ns/1ps
module tb_cache_sa_wb;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] address = '0;
    logic [63:0] data_in = '0;
    logic [7:0]  bytemask = '0;
    logic        write = 1'b0;
    logic        start_access = 1'b0;
    logic        access_done;
    logic [63:0] data_out;
    logic [19:0] mem_address;
    logic [63:0] mem_data_out;
    logic        mem_write;
    logic        mem_start;
    logic        mem_done = 1'b0;
    logic [63:0] mem_data_in = '0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_sa_wb dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .bytemask(bytemask),
        .write(write), .start_access(start_access), .access_done(access_done), .data_out(data_out),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_write(mem_write),
        .mem_start(mem_start), .mem_done(mem_done), .mem_data_in(mem_data_in)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input logic [19:0] a);
        return {12'hABC, a, 12'h123, a};
    endfunction

    // Backing memory: untouched words read as init_word(address).
    logic [63:0] bmem   [int];
    logic [19:0] rd_log [int];
    logic [19:0] wr_log [int];
    int rd_total = 0;
    int wr_total = 0;
    int mcnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_done <= 1'b0;
            mcnt     <= 0;
        end else begin
            mem_done <= 1'b0;
            if (mem_start && !mem_done) begin
                if (mcnt == LAT - 1) begin
                    mcnt     <= 0;
                    mem_done <= 1'b1;
                    if (mem_write) begin
                        bmem[int'(mem_address)] = mem_data_out;
                        wr_log[wr_total] = mem_address;
                        wr_total = wr_total + 1;
                    end else begin
                        mem_data_in <= bmem.exists(int'(mem_address)) ? bmem[int'(mem_address)] : init_word(mem_address);
                        rd_log[rd_total] = mem_address;
                        rd_total = rd_total + 1;
                    end
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp;
        int          nrd;
        int          nwr;
        logic [19:0] rd0;
        logic [19:0] wr0;
    } vec_t;

    vec_t vt[18];
    int n_vec = 0;
    int n_err = 0;
    int exp_hit = 0, exp_miss = 0, exp_wb = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic [19:0] a, input logic w, input logic [63:0] d, input logic [7:0] m,
                             output logic [63:0] rdata, output int lat, output int mcyc);
        bit got;
        @(negedge clk);
        address = a; write = w; data_in = d; bytemask = m; start_access = 1'b1;
        lat = 0; mcyc = 0; rdata = '0; got = 0;
        while (lat < 300 && !got) begin
            @(posedge clk); #1;
            lat++;
            if (mem_start) mcyc++;
            if (access_done) begin
                got = 1;
                rdata = data_out;
            end
        end
        chk($sformatf("access_done seen addr=%h", a), 64'(got), 64'd1);
        @(negedge clk);
        start_access = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("single done pulse addr=%h", a), 64'(access_done), 64'd0);
    endtask

    task automatic apply_vec(input int i);
        int rd_base, wr_base, lat, mcyc;
        logic [63:0] rdata;
        rd_base = rd_total;
        wr_base = wr_total;
        do_access(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].mask, rdata, lat, mcyc);
        if (!vt[i].wr) chk($sformatf("v%0d data", i), rdata, vt[i].exp);
        chk($sformatf("v%0d mem reads", i), 64'(rd_total - rd_base), 64'(vt[i].nrd));
        chk($sformatf("v%0d mem writes", i), 64'(wr_total - wr_base), 64'(vt[i].nwr));
        for (int k = 0; k < vt[i].nrd; k++)
            if (rd_base + k < rd_total)
                chk($sformatf("v%0d rd addr %0d", i, k), 64'(rd_log[rd_base+k]), 64'(vt[i].rd0 + 20'(8*k)));
        for (int k = 0; k < vt[i].nwr; k++)
            if (wr_base + k < wr_total)
                chk($sformatf("v%0d wr addr %0d", i, k), 64'(wr_log[wr_base+k]), 64'(vt[i].wr0 + 20'(8*k)));
        if (vt[i].nrd + vt[i].nwr == 0) begin
            chk($sformatf("v%0d hit latency", i), 64'(lat), 64'd2);
            chk($sformatf("v%0d hit mem_start cycles", i), 64'(mcyc), 64'd0);
            exp_hit++;
        end else begin
            exp_miss++;
            exp_wb += vt[i].nwr / 2;
        end
        $display("vec %0d addr=%h wr=%0d data=%h lat=%0d rd=%0d wr=%0d", i, vt[i].addr, vt[i].wr, rdata,
                 lat, rd_total - rd_base, wr_total - wr_base);
    endtask

    initial begin
        logic [19:0] bb_a [4];
        logic [63:0] bb_d [4];
        int cyc, ms, rd_base;
        bit got;

        //          addr     wr    wdata                   mask   expected read           nrd nwr rd0      wr0
        vt[0]  = '{20'h000, 1'b0, 64'h0,                  8'h00, 64'hABC00000_12300000, 2, 0, 20'h000, 20'h0};
        vt[1]  = '{20'h008, 1'b0, 64'h0,                  8'h00, 64'hABC00008_12300008, 0, 0, 20'h000, 20'h0};
        vt[2]  = '{20'h000, 1'b1, 64'h11223344_55667788, 8'h0F, 64'h0,                  0, 0, 20'h000, 20'h0};
        vt[3]  = '{20'h000, 1'b0, 64'h0,                  8'h00, 64'hABC00000_55667788, 0, 0, 20'h000, 20'h0};
        vt[4]  = '{20'h080, 1'b0, 64'h0,                  8'h00, 64'hABC00080_12300080, 2, 0, 20'h080, 20'h0};
        vt[5]  = '{20'h100, 1'b0, 64'h0,                  8'h00, 64'hABC00100_12300100, 2, 2, 20'h100, 20'h000};
        vt[6]  = '{20'h000, 1'b0, 64'h0,                  8'h00, 64'hABC00000_55667788, 2, 0, 20'h000, 20'h0};
        vt[7]  = '{20'h108, 1'b0, 64'h0,                  8'h00, 64'hABC00108_12300108, 0, 0, 20'h000, 20'h0};
        vt[8]  = '{20'h018, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hF0, 64'h0,                  2, 0, 20'h010, 20'h0};
        vt[9]  = '{20'h018, 1'b0, 64'h0,                  8'h00, 64'hDEADBEEF_12300018, 0, 0, 20'h000, 20'h0};
        vt[10] = '{20'h010, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 64'h0,                  0, 0, 20'h000, 20'h0};
        vt[11] = '{20'h010, 1'b0, 64'h0,                  8'h00, 64'hABC00010_12300010, 0, 0, 20'h000, 20'h0};
        vt[12] = '{20'h008, 1'b1, 64'h01234567_89ABCDEF, 8'hFF, 64'h0,                  0, 0, 20'h000, 20'h0};
        vt[13] = '{20'h008, 1'b0, 64'h0,                  8'h00, 64'h01234567_89ABCDEF, 0, 0, 20'h000, 20'h0};
        // after the mid-fill reset: cache empty, dirty 0x8 write lost, rr pointers back to 0
        vt[14] = '{20'h200, 1'b0, 64'h0,                  8'h00, 64'hABC00200_12300200, 2, 0, 20'h200, 20'h0};
        vt[15] = '{20'h008, 1'b0, 64'h0,                  8'h00, 64'hABC00008_12300008, 2, 0, 20'h000, 20'h0};
        vt[16] = '{20'h100, 1'b0, 64'h0,                  8'h00, 64'hABC00100_12300100, 2, 0, 20'h100, 20'h0};
        vt[17] = '{20'h208, 1'b0, 64'h0,                  8'h00, 64'hABC00208_12300208, 2, 0, 20'h200, 20'h0};

        bb_a[0] = 20'h100; bb_d[0] = 64'hABC00100_12300100;
        bb_a[1] = 20'h008; bb_d[1] = 64'h01234567_89ABCDEF;
        bb_a[2] = 20'h018; bb_d[2] = 64'hDEADBEEF_12300018;
        bb_a[3] = 20'h108; bb_d[3] = 64'hABC00108_12300108;

        @(posedge clk); #1;
        chk("reset access_done", 64'(access_done), 64'd0);
        chk("reset data_out", data_out, 64'd0);
        chk("reset mem_start", 64'(mem_start), 64'd0);
        chk("reset mem_write", 64'(mem_write), 64'd0);
        chk("reset mem_address", 64'(mem_address), 64'd0);
        chk("reset mem_data_out", mem_data_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) apply_vec(i);

        // Back-to-back hits with start_access held high.
        @(negedge clk);
        address = bb_a[0]; write = 1'b0; start_access = 1'b1;
        ms = 0;
        rd_base = rd_total;
        for (int k = 0; k < 4; k++) begin
            cyc = 0; got = 0;
            while (cyc < 20 && !got) begin
                @(posedge clk); #1;
                cyc++;
                if (mem_start) ms++;
                if (access_done) got = 1;
            end
            chk($sformatf("b2b %0d spacing", k), 64'(cyc), 64'd2);
            chk($sformatf("b2b %0d data", k), data_out, bb_d[k]);
            $display("b2b %0d addr=%h data=%h spacing=%0d", k, bb_a[k], data_out, cyc);
            exp_hit++;
            @(negedge clk);
            if (k < 3) address = bb_a[k+1];
            else       start_access = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b done drops", 64'(access_done), 64'd0);
        chk("b2b mem traffic", 64'(ms + rd_total - rd_base), 64'd0);

        // Reset pulsed while the second fill beat is outstanding.
        @(negedge clk);
        address = 20'h200; write = 1'b0; start_access = 1'b1;
        cyc = 0; got = 0;
        while (cyc < 100 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_start && mem_address == 20'h208) got = 1;
        end
        chk("fill word1 reached", 64'(got), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort mem_start", 64'(mem_start), 64'd0);
        chk("abort access_done", 64'(access_done), 64'd0);
        chk("abort mem_address", 64'(mem_address), 64'd0);
        $display("reset pulse during fill beat 1: mem_start=%0d mem_address=%h", mem_start, mem_address);
        start_access = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 14; i < 18; i++) apply_vec(i);

`ifdef CACHE_STATS_EN
        chk("stats hit_count", 64'(hit_count), 64'(exp_hit));
        chk("stats miss_count", 64'(miss_count), 64'(exp_miss));
        chk("stats wb_count", 64'(wb_count), 64'(exp_wb));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
